ahb_write_master: RTL

Single-clock AHB-Lite write master on the read side of the 64-bit asynchronous data FIFO of the AXI-to-AHB bridge. Per accepted write command it pops `cmd_len+1` beats from the FIFO and issues them as an undefined-length INCR burst. It inserts BUSY when the FIFO runs dry and restarts with NONSEQ at 1 KB boundaries. On an ERROR response it aborts the burst and drains the unsent beats, so the FIFO stays aligned with the command stream.

---
 rtl/ahb_write_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ahb_write_master.sv
// AHB-Lite write master draining the bridge data FIFO as undefined-length INCR bursts.
// Inserts BUSY on FIFO underrun, restarts with NONSEQ at 1 KB boundaries, drains on ERROR.
module ahb_write_master #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 4
) (
    input  logic              rclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [2:0]        cmd_size,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    output logic              done,
    output logic              err
);
    localparam int unsigned CNT_W = LEN_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_ERR   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] BURST_INCR = 3'b001;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [2:0]        size;
    logic [CNT_W-1:0]  acnt;
    logic [CNT_W-1:0]  fcnt;
    logic [DATA_W-1:0] buf_data;
    logic              buf_valid;
    logic              first;
    logic              acc;
    logic              data_err;
    logic              cmd_fire;

    // Transfer type is decoded from registered state only
    always_comb begin
        htrans = TR_IDLE;
        if (state == S_ADDR) begin
            if (buf_valid) begin
                htrans = first ? TR_NONSEQ : TR_SEQ;
            end else begin
                htrans = first ? TR_IDLE : TR_BUSY;
            end
        end
    end

    assign haddr     = cur_addr;
    assign hsize     = size;
    assign hwrite    = (htrans != TR_IDLE);
    assign hburst    = hwrite ? BURST_INCR : 3'b000;
    assign acc       = hready && htrans[1];
    assign addr_inc  = cur_addr + (ADDR_W'(1) << size);
    assign data_err  = hresp && !hready && ((state == S_ADDR) || (state == S_LAST));
    assign cmd_ready = (state == S_IDLE) && !reset;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign done      = (state == S_LAST) && hready && !hresp;
    assign err       = (state == S_DRAIN) && (fcnt == '0);

    // Drain pops ignore the holding buffer so the FIFO stays in step with commands
    assign fifo_rd_en = !fifo_empty && (fcnt != '0) &&
                        (((state == S_ADDR) && (!buf_valid || acc)) || (state == S_DRAIN));

    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_fire) state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (data_err) begin
                    state_nxt = S_ERR;
                end else if (acc && (acnt == CNT_W'(1))) begin
                    state_nxt = S_LAST;
                end
            end
            S_LAST: begin
                if (data_err) begin
                    state_nxt = S_ERR;
                end else if (hready && !hresp) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (hready) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (fcnt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst datapath: address/count tracking, one-beat holding buffer, data-phase register
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            cur_addr  <= '0;
            size      <= '0;
            acnt      <= '0;
            fcnt      <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
            first     <= 1'b0;
            hwdata    <= '0;
        end else begin
            if (cmd_fire) begin
                cur_addr <= cmd_addr;
                size     <= cmd_size;
                acnt     <= CNT_W'(cmd_len) + CNT_W'(1);
                fcnt     <= CNT_W'(cmd_len) + CNT_W'(1);
                first    <= 1'b1;
            end
            if (fifo_rd_en) begin
                fcnt     <= fcnt - CNT_W'(1);
                buf_data <= fifo_rdata;
            end
            if (acc) begin
                hwdata   <= buf_data;
                acnt     <= acnt - CNT_W'(1);
                cur_addr <= addr_inc;
                first    <= (addr_inc[9:0] == 10'd0);
            end
            if (state == S_DRAIN) begin
                buf_valid <= 1'b0;
            end else if (fifo_rd_en) begin
                buf_valid <= 1'b1;
            end else if (acc) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule
